// File: rtl/fpu_issue_scheduler.sv
// FPU issue scheduler: steers ops to the pipelined or iterative path and
// books the shared writeback port through a shifting reservation table.
module fpu_issue_scheduler #(
    parameter int TAG_W    = 4,
    parameter int PIPE_LAT = 4,
    parameter int ITER_LAT = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             pipe_issue,
    output logic [2:0]       pipe_op,
    output logic             iter_start,
    output logic [2:0]       iter_op,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_src,
    output logic             illegal_op,
    output logic             busy
);
    localparam int N  = ITER_LAT + 1;
    localparam int CW = $clog2(ITER_LAT + 1);
    // Countdown hits zero in the writeback cycle, so the load is one short.
    localparam logic [CW-1:0] CNT_LOAD = CW'(ITER_LAT - 1);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_SQRT = 3'd4
    } op_e;

    // Slot 0 is the registered writeback; slot k writes back k cycles out.
    logic [N-1:0]     vld_q, vld_d;
    logic [N-1:0]     src_q, src_d;
    logic [TAG_W-1:0] tag_q [N];
    logic [TAG_W-1:0] tag_d [N];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_pipe, is_iter, is_ill, accept;

    always_comb begin
        is_pipe = 1'b0;
        is_iter = 1'b0;
        is_ill  = 1'b0;
        unique case (req_op)
            OP_ADD, OP_SUB, OP_MUL: is_pipe = 1'b1;
            OP_DIV, OP_SQRT:        is_iter = 1'b1;
            default:                is_ill  = 1'b1;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        if (reset_n && !flush) begin
            unique case (1'b1)
                is_pipe: req_ready = !vld_q[PIPE_LAT];
                is_iter: req_ready = (cnt_q == '0) && !vld_q[ITER_LAT];
                is_ill:  req_ready = 1'b1;
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign accept     = req_valid && req_ready;
    assign pipe_issue = accept && is_pipe;
    assign iter_start = accept && is_iter;
    assign illegal_op = accept && is_ill;
    assign pipe_op    = pipe_issue ? req_op : 3'd0;
    assign iter_op    = iter_start ? req_op : 3'd0;

    always_comb begin
        vld_d = '0;
        src_d = '0;
        for (int k = 0; k < N; k++) tag_d[k] = '0;
        for (int k = 0; k < N - 1; k++) begin
            vld_d[k] = vld_q[k+1];
            src_d[k] = src_q[k+1];
            tag_d[k] = tag_q[k+1];
        end
        cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        if (pipe_issue) begin
            vld_d[PIPE_LAT-1] = 1'b1;
            src_d[PIPE_LAT-1] = 1'b0;
            tag_d[PIPE_LAT-1] = req_tag;
        end
        if (iter_start) begin
            vld_d[ITER_LAT-1] = 1'b1;
            src_d[ITER_LAT-1] = 1'b1;
            tag_d[ITER_LAT-1] = req_tag;
            cnt_d             = CNT_LOAD;
        end
        if (flush) begin
            vld_d = '0;
            src_d = '0;
            for (int k = 0; k < N; k++) tag_d[k] = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            src_q <= '0;
            cnt_q <= '0;
            for (int k = 0; k < N; k++) tag_q[k] <= '0;
        end else begin
            vld_q <= vld_d;
            src_q <= src_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < N; k++) tag_q[k] <= tag_d[k];
        end
    end

    assign wb_valid = vld_q[0];
    assign wb_tag   = tag_q[0];
    assign wb_src   = src_q[0];
    assign busy     = (|vld_q[N-1:1]) || (cnt_q != '0);

    // A booking must never land on a slot another result already holds.
    a_no_wb_clash: assert property (@(posedge clk) disable iff (!reset_n)
        !(pipe_issue && vld_q[PIPE_LAT]) && !(iter_start && vld_q[ITER_LAT]));

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Bench for fpu_issue_scheduler: directed sequences plus random traffic,
// checked against a cycle-keyed writeback schedule model.
module tb_fpu_issue_scheduler;
    localparam int TAG_W    = 4;
    localparam int PIPE_LAT = 4;
    localparam int ITER_LAT = 12;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             pipe_issue;
    logic [2:0]       pipe_op;
    logic             iter_start;
    logic [2:0]       iter_op;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_src;
    logic             illegal_op;
    logic             busy;

    fpu_issue_scheduler #(
        .TAG_W(TAG_W), .PIPE_LAT(PIPE_LAT), .ITER_LAT(ITER_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_tag(req_tag), .flush(flush),
        .pipe_issue(pipe_issue), .pipe_op(pipe_op),
        .iter_start(iter_start), .iter_op(iter_op),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_src(wb_src),
        .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Model: absolute cycle -> {src, tag} of the writeback due then.
    logic [TAG_W:0] sched [int];
    int iter_wb = -1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h",
                     tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_ready(int c, logic [2:0] op, logic fl);
        if (fl) return 1'b0;
        if (op <= 3'd2) return !sched.exists(c + PIPE_LAT);
        if (op <= 3'd4) return (iter_wb <= c) && !sched.exists(c + ITER_LAT);
        return 1'b1;
    endfunction

    function automatic bit m_busy(int c);
        bit b = 1'b0;
        foreach (sched[k]) if (k > c) b = 1'b1;
        return b;
    endfunction

    // Entered at posedge+1; checks at the falling edge, model steps at posedge.
    task automatic run_cycle(input logic v, input logic [2:0] op,
                             input logic [TAG_W-1:0] tg, input logic fl,
                             output bit acc);
        int c;
        bit er, ewb;
        logic [TAG_W:0] e;
        req_valid = v;
        req_op    = op;
        req_tag   = tg;
        flush     = fl;
        #4;
        c   = cyc;
        er  = m_ready(c, op, fl);
        acc = v && er;
        ewb = sched.exists(c);
        e   = ewb ? sched[c] : '0;
        check("req_ready", req_ready, er);
        check("pipe_issue", pipe_issue, acc && op <= 3'd2);
        check("pipe_op", pipe_op, (acc && op <= 3'd2) ? op : 3'd0);
        check("iter_start", iter_start, acc && (op == 3'd3 || op == 3'd4));
        check("iter_op", iter_op,
              (acc && (op == 3'd3 || op == 3'd4)) ? op : 3'd0);
        check("illegal_op", illegal_op, acc && op >= 3'd5);
        check("wb_valid", wb_valid, ewb);
        if (ewb) begin
            check("wb_tag", wb_tag, e[TAG_W-1:0]);
            check("wb_src", wb_src, e[TAG_W]);
        end
        check("busy", busy, m_busy(c));
        @(posedge clk);
        if (acc && op <= 3'd2) sched[c + PIPE_LAT] = {1'b0, tg};
        if (acc && (op == 3'd3 || op == 3'd4)) begin
            sched[c + ITER_LAT] = {1'b1, tg};
            iter_wb = c + ITER_LAT;
        end
        if (fl) begin
            foreach (sched[k]) if (k > c) sched.delete(k);
            iter_wb = -1;
        end
        if (sched.exists(c)) sched.delete(c);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [TAG_W-1:0] tg);
        bit acc;
        int n = 0;
        do begin
            run_cycle(1'b1, op, tg, 1'b0, acc);
            n++;
        end while (!acc && n < 40);
        if (!acc) check("send_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) run_cycle(1'b0, 3'd0, '0, 1'b0, acc);
    endtask

    task automatic check_reset_outputs();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_tag", wb_tag, 0);
        check("rst_wb_src", wb_src, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_pipe_issue", pipe_issue, 0);
        check("rst_iter_start", iter_start, 0);
        check("rst_illegal", illegal_op, 0);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        flush     = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        sched.delete();
        iter_wb = -1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc, hv, fl;
        logic [2:0] hop;
        logic [TAG_W-1:0] htag;
        int r;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_tag   = '0;
        flush     = 1'b0;
        #12;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        send(3'd0, 4'd3);
        idle(6);

        send(3'd3, 4'd1);
        idle(7);
        send(3'd2, 4'd2);
        idle(14);

        for (int i = 0; i < 10; i++) send(3'd1, TAG_W'(i));
        idle(6);

        send(3'd4, 4'd5);
        send(3'd4, 4'd6);
        idle(14);

        send(3'd0, 4'd7);
        idle(1);
        run_cycle(1'b1, 3'd0, 4'd8, 1'b1, acc);
        req_valid = 1'b0;
        idle(4);

        send(3'd6, 4'd4);
        idle(5);

        send(3'd3, 4'd9);
        idle(4);
        do_reset();
        idle(15);

        hv = 1'b0;
        hop = '0;
        htag = '0;
        for (int i = 0; i < 600; i++) begin
            if (!hv && $urandom_range(0, 99) < 55) begin
                r = $urandom_range(0, 15);
                if (r < 9)       hop = 3'(r % 3);
                else if (r < 13) hop = 3'(3 + r % 2);
                else             hop = 3'(5 + r % 3);
                htag = TAG_W'($urandom);
                hv = 1'b1;
            end
            fl = ($urandom_range(0, 29) == 0);
            run_cycle(hv, hop, htag, fl, acc);
            if (acc) hv = 1'b0;
            if (i == 300) begin
                do_reset();
                hv = 1'b0;
            end
        end
        req_valid = 1'b0;
        idle(16);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
endmodule
